// File: rtl/fadd_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fadd_pipe : 3-stage IEEE-754 adder/subtractor with valid/ready flow      |
// |             (swap/align -> add/sub -> normalise/round), RNE, FTZ.        |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module fadd_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   x1,
  input  logic [EXP_W+MAN_W:0]   x2,
  input  logic                   op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   y,
  output logic [2:0]             flags
);
  localparam int c_W         = 1 + EXP_W + MAN_W;
  localparam int c_SIG_W     = MAN_W + 4;
  localparam int c_SHIFT_MAX = MAN_W + 3;
  localparam int c_SH_W      = $clog2(c_SIG_W);
  localparam int c_E_W       = EXP_W + c_SH_W + 2;
  localparam int c_M_W       = MAN_W + 2;
  localparam logic [EXP_W-1:0] c_EXP_ONES = '1;
  localparam logic [c_W-1:0]   c_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [c_E_W-1:0] c_EXP_MAX = c_E_W'((2**EXP_W) - 1);
  localparam logic signed [c_E_W-1:0] c_EXP_MIN = c_E_W'(1);

  function automatic logic [c_SH_W-1:0] f_lzc(input logic [c_SIG_W-1:0] v);
    logic [c_SH_W-1:0] n;
    n = '0;
    for (int i = 0; i < c_SIG_W; i++)
      if (v[i]) n = c_SH_W'(c_SIG_W - 1 - i);
    return n;
  endfunction

  logic w_adv;
  logic r1_valid, r2_valid, r3_valid;
  logic [c_W-1:0] r_y;
  logic [2:0]     r_flags;

  assign w_adv     = !r3_valid || out_ready;
  assign in_ready  = rst || w_adv;
  assign out_valid = r3_valid;
  assign y         = r_y;
  assign flags     = r_flags;

  // ---------------- S1: classify, swap, align ----------------
  logic             w_a_sign, w_b_sign;
  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic [MAN_W-1:0] w_a_frac, w_b_frac;
  logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_a_snan, w_b_snan;

  assign w_a_sign = x1[c_W-1];
  assign w_b_sign = x2[c_W-1] ^ op;
  assign w_a_exp  = x1[c_W-2:MAN_W];
  assign w_b_exp  = x2[c_W-2:MAN_W];
  assign w_a_frac = x1[MAN_W-1:0];
  assign w_b_frac = x2[MAN_W-1:0];
  assign w_a_zero = (w_a_exp == '0);
  assign w_b_zero = (w_b_exp == '0);
  assign w_a_inf  = (w_a_exp == c_EXP_ONES) && (w_a_frac == '0);
  assign w_b_inf  = (w_b_exp == c_EXP_ONES) && (w_b_frac == '0);
  assign w_a_nan  = (w_a_exp == c_EXP_ONES) && (w_a_frac != '0);
  assign w_b_nan  = (w_b_exp == c_EXP_ONES) && (w_b_frac != '0);
  assign w_a_snan = w_a_nan && !w_a_frac[MAN_W-1];
  assign w_b_snan = w_b_nan && !w_b_frac[MAN_W-1];

  logic               w_swap, w_big_sign;
  logic [EXP_W-1:0]   w_big_exp, w_sml_exp, w_exp_diff;
  logic [c_SIG_W-1:0] w_big_sig, w_sml_raw, w_sml_mask, w_sml_sig;
  logic [c_SH_W-1:0]  w_shamt;

  always_comb begin
    w_swap     = x2[c_W-2:0] > x1[c_W-2:0];
    w_big_sign = w_swap ? w_b_sign : w_a_sign;
    w_big_exp  = w_swap ? w_b_exp  : w_a_exp;
    w_sml_exp  = w_swap ? w_a_exp  : w_b_exp;
    w_big_sig  = {1'b1, (w_swap ? w_b_frac : w_a_frac), 3'b000};
    w_sml_raw  = {1'b1, (w_swap ? w_a_frac : w_b_frac), 3'b000};
    w_exp_diff = w_big_exp - w_sml_exp;
    w_shamt    = (int'(w_exp_diff) > c_SHIFT_MAX) ? c_SH_W'(c_SHIFT_MAX) : c_SH_W'(w_exp_diff);
    w_sml_mask = ~({c_SIG_W{1'b1}} << w_shamt);
    w_sml_sig  = w_sml_raw >> w_shamt;
    // Everything shifted past the round bit collapses into the sticky LSB.
    w_sml_sig[0] = w_sml_sig[0] | (|(w_sml_raw & w_sml_mask));
  end

  logic           w_spec;
  logic [c_W-1:0] w_spec_y;
  logic [2:0]     w_spec_fl;

  always_comb begin
    w_spec    = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;
    w_spec_y  = x1;
    w_spec_fl = 3'b000;
    if (w_a_nan || w_b_nan) begin
      w_spec_y  = c_QNAN;
      w_spec_fl = {w_a_snan | w_b_snan, 2'b00};
    end else if (w_a_inf && w_b_inf) begin
      if (w_a_sign == w_b_sign) begin
        w_spec_y = {w_a_sign, c_EXP_ONES, {MAN_W{1'b0}}};
      end else begin
        w_spec_y  = c_QNAN;
        w_spec_fl = 3'b100;
      end
    end else if (w_a_inf) begin
      w_spec_y = {w_a_sign, c_EXP_ONES, {MAN_W{1'b0}}};
    end else if (w_b_inf) begin
      w_spec_y = {w_b_sign, c_EXP_ONES, {MAN_W{1'b0}}};
    end else if (w_a_zero && w_b_zero) begin
      w_spec_y = {w_a_sign & w_b_sign, {(c_W-1){1'b0}}};
    end else if (w_a_zero) begin
      w_spec_y = {w_b_sign, x2[c_W-2:0]};
    end
  end

  logic               r1_sign, r1_sub, r1_spec;
  logic [EXP_W-1:0]   r1_exp;
  logic [c_SIG_W-1:0] r1_big_sig, r1_sml_sig;
  logic [c_W-1:0]     r1_spec_y;
  logic [2:0]         r1_spec_fl;

  // ---------------- S2: add / subtract ----------------
  logic [c_SIG_W:0] w_sum;
  assign w_sum = r1_sub ? ({1'b0, r1_big_sig} - {1'b0, r1_sml_sig})
                        : ({1'b0, r1_big_sig} + {1'b0, r1_sml_sig});

  logic             r2_sign, r2_spec;
  logic [EXP_W-1:0] r2_exp;
  logic [c_SIG_W:0] r2_sum;
  logic [c_W-1:0]   r2_spec_y;
  logic [2:0]       r2_spec_fl;

  // ---------------- S3: normalise, round, range check ----------------
  logic [c_SH_W-1:0]        w_lz;
  logic [c_SIG_W-1:0]       w_norm;
  logic signed [c_E_W-1:0]  w_exp_n, w_exp_r;
  logic                     w_round_up;
  logic [c_M_W-1:0]         w_mant_r;
  logic [c_W-1:0]           w_res_y;
  logic [2:0]               w_res_fl;

  always_comb begin
    w_lz = f_lzc(r2_sum[c_SIG_W-1:0]);
    if (r2_sum[c_SIG_W]) begin
      w_norm  = r2_sum[c_SIG_W:1] | {{(c_SIG_W-1){1'b0}}, r2_sum[0]};
      w_exp_n = c_E_W'(r2_exp) + c_E_W'(1);
    end else begin
      w_norm  = r2_sum[c_SIG_W-1:0] << w_lz;
      w_exp_n = c_E_W'(r2_exp) - c_E_W'(w_lz);
    end
    w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_mant_r   = {1'b0, w_norm[c_SIG_W-1:3]} + c_M_W'(w_round_up);
    w_exp_r    = w_exp_n + c_E_W'(w_mant_r[MAN_W+1]);
    w_res_y    = {r2_sign, w_exp_r[EXP_W-1:0], w_mant_r[MAN_W-1:0]};
    w_res_fl   = 3'b000;
    if (r2_spec) begin
      w_res_y  = r2_spec_y;
      w_res_fl = r2_spec_fl;
    end else if (!(w_mant_r[MAN_W+1] | w_mant_r[MAN_W])) begin
      // No leading one anywhere means exact cancellation.
      w_res_y = '0;
    end else if (w_exp_r >= c_EXP_MAX) begin
      w_res_y  = {r2_sign, c_EXP_ONES, {MAN_W{1'b0}}};
      w_res_fl = 3'b010;
    end else if (w_exp_r < c_EXP_MIN) begin
      w_res_y  = {r2_sign, {(c_W-1){1'b0}}};
      w_res_fl = 3'b001;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r2_valid <= 1'b0;
      r3_valid <= 1'b0;
      r_y      <= '0;
      r_flags  <= '0;
    end else if (w_adv) begin
      r1_valid <= in_valid;
      r2_valid <= r1_valid;
      r3_valid <= r2_valid;
      if (r2_valid) begin
        r_y     <= w_res_y;
        r_flags <= w_res_fl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r1_sign    <= w_big_sign;
      r1_sub     <= w_a_sign ^ w_b_sign;
      r1_spec    <= w_spec;
      r1_exp     <= w_big_exp;
      r1_big_sig <= w_big_sig;
      r1_sml_sig <= w_sml_sig;
      r1_spec_y  <= w_spec_y;
      r1_spec_fl <= w_spec_fl;
      r2_sign    <= r1_sign;
      r2_spec    <= r1_spec;
      r2_exp     <= r1_exp;
      r2_sum     <= w_sum;
      r2_spec_y  <= r1_spec_y;
      r2_spec_fl <= r1_spec_fl;
    end
  end
endmodule
`default_nettype wire
